load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 65 ++++++
 rtl/load_store_unit_load_align.sv | 29 ++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: FSM state, funct3 size codes, size/alignment helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Undefined encodings fall through to a word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t s;
    unique case (f3)
      LS_B, LS_BU: s = SZ_B;
      LS_H, LS_HU: s = SZ_H;
      default:     s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == LS_B) || (f3 == LS_H);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    unique case (f3_size(f3))
      SZ_H:    m = off[0];
      SZ_W:    m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Byte lane of the access; sub-size offset bits are dropped.
  function automatic logic [1:0] lane_shift(
    input lsu_size_t s,
    input logic [1:0] off
  );
    logic [1:0] l;
    unique case (s)
      SZ_B:    l = off;
      SZ_H:    l = {off[1], 1'b0};
      default: l = 2'b00;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane steering: shift the bus word down to the accessed lane,
// then sign- or zero-extend to 32 bits.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  lsu_size_t   size;
  logic        sext;
  logic [31:0] shifted;

  assign size    = f3_size(funct3_i);
  assign sext    = f3_signed(funct3_i);
  assign shifted = rdata_i >> {lane_shift(size, offset_i), 3'b000};

  always_comb begin
    data_o = shifted;
    unique case (size)
      SZ_B:    data_o = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: IDLE/ISSUE/WAIT/DONE bus FSM with pipeline stall.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  lsu_state_t        state_q, state_d;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              mis_q;
  logic              trap;
  logic [31:0]       load_data;
  lsu_size_t         size_q;
  logic [1:0]        off_q;
  logic [3:0]        be;
  logic [31:0]       wd;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap       = misaligned(funct3_i, addr_i[1:0]);
  assign misalign_o = (state_q == LSU_DONE) & mis_q;
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:
        if (req_valid_i) state_d = trap ? LSU_DONE : LSU_ISSUE;
      LSU_ISSUE:
        if (bus_gnt_i) state_d = write_q ? LSU_DONE : LSU_WAIT;
      LSU_WAIT:
        if (bus_rvalid_i) state_d = LSU_DONE;
      default:
        state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= LSU_IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LSU_IDLE && req_valid_i) begin
        write_q <= req_write_i;
        f3_q    <= funct3_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        mis_q   <= trap;
      end
      if (state_q == LSU_WAIT && bus_rvalid_i)
        rdata_q <= load_data;
    end
  end

  assign size_q = f3_size(f3_q);
  assign off_q  = addr_q[1:0];

  load_align u_align (
    .rdata_i  (bus_rdata_i),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  // Sub-word stores replicate the datum so every enabled lane sees it.
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    unique case (1'b1)
      (size_q == SZ_B): begin
        be = 4'b0001 << off_q;
        wd = {4{wdata_q[7:0]}};
      end
      (size_q == SZ_H): begin
        be = 4'b0011 << {off_q[1], 1'b0};
        wd = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus_req_o     = (state_q == LSU_ISSUE);
  assign bus_we_o      = bus_req_o & write_q;
  assign bus_be_o      = bus_req_o ? be : 4'b0000;
  assign bus_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata_o   = wd;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == LSU_DONE) & ~write_q & ~mis_q;
  assign stall_o       = reset_ni & req_valid_i & (state_q != LSU_DONE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expectations,
// a negedge monitor pops them as bus grants, load results and traps appear.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .req_valid_i   (req_valid_i),
    .req_write_i   (req_write_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misalign_o    (misalign_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_rvalid_i  (bus_rvalid_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  int          stall_q[$];
  int          mis_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int srun = 0;
  logic [31:0] last_rd = 32'h0;
  bus_exp_t mon_e;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event @%0t", nm, $time);
  endtask

  always @(negedge clk_i) begin
    if (!reset_ni) begin
      srun = 0;
    end else begin
      if (bus_req_o && bus_gnt_i) begin
        if (bus_q.size() == 0) unexp("bus_req");
        else begin
          mon_e = bus_q.pop_front();
          check("bus_we", {31'h0, bus_we_o}, {31'h0, mon_e.we});
          check("bus_addr", bus_addr_o, mon_e.addr);
          check("bus_be", {28'h0, bus_be_o}, {28'h0, mon_e.be});
          if (mon_e.we) check("bus_wdata", bus_wdata_o, mon_e.wdata);
        end
      end
      if (rdata_valid_o) begin
        if (rd_q.size() == 0) unexp("rdata_valid");
        else check("rdata", rdata_o, rd_q.pop_front());
      end
      if (misalign_o) begin
        if (mis_q.size() == 0) unexp("misalign");
        else void'(mis_q.pop_front());
      end
      if (stall_o) srun++;
      else if (srun > 0) begin
        if (stall_q.size() == 0) unexp("stall_run");
        else check("stall_cycles", srun, stall_q.pop_front());
        srun = 0;
      end
    end
  end

  // trap: expect a misalign pulse instead of a bus access and data
  task automatic txn(
    input logic w, input logic [2:0] f3, input logic [31:0] a,
    input logic [31:0] wd, input logic [31:0] rd_bus,
    input int gdel, input int rdel, input logic noise, input logic trap,
    input logic [31:0] e_addr, input logic [3:0] e_be,
    input logic [31:0] e_wd, input logic [31:0] e_rd, input int e_stall
  );
    int n, gcnt, wcnt;
    logic granted;
    bus_exp_t e;
    if (trap) mis_q.push_back(1);
    else begin
      e.we = w; e.addr = e_addr; e.be = e_be; e.wdata = e_wd;
      bus_q.push_back(e);
      if (!w) begin
        rd_q.push_back(e_rd);
        last_rd = e_rd;
      end
    end
    stall_q.push_back(e_stall);
    req_valid_i = 1'b1; req_write_i = w; funct3_i = f3;
    addr_i = a; wdata_i = wd;
    if (noise) begin bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5A5A5A5A; end
    n = 0; gcnt = 0; wcnt = 0; granted = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
      if (!stall_o) break;
      n++;
      if (n > 40) begin unexp("txn_timeout"); break; end
      if (granted) begin
        wcnt++;
        if (wcnt == rdel) begin bus_rvalid_i = 1'b1; bus_rdata_i = rd_bus; end
      end else if (bus_req_o) begin
        if (gcnt == gdel) begin bus_gnt_i = 1'b1; granted = 1'b1; end
        else if (noise) begin bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA5A5A5A5; end
        gcnt++;
      end
    end
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_exp_t e;
    #3;
    check("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
    check("rst_bus_be", {28'h0, bus_be_o}, 32'h0);
    check("rst_bus_addr", bus_addr_o, 32'h0);
    check("rst_bus_wdata", bus_wdata_o, 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_rvalid", {31'h0, rdata_valid_o}, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    // w f3 addr wdata busrdata gdel rdel noise trap | addr be wdata rdata stall
    txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0,
        32'h100, 4'b1111, 32'hDEADBEEF, 0, 2);
    txn(0, 3'b000, 32'h203, 0, 32'h80FFFFFF, 0, 3, 1, 0,
        32'h200, 4'b1000, 0, 32'hFFFFFF80, 5);
    txn(1, 3'b001, 32'h2, 32'h1234ABCD, 0, 1, 0, 1, 0,
        32'h0, 4'b1100, 32'hABCDABCD, 0, 3);
    txn(0, 3'b101, 32'h6, 0, 32'h80011234, 0, 1, 0, 0,
        32'h4, 4'b1100, 0, 32'h00008001, 3);
    txn(1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0, 0, 0,
        32'h100, 4'b0010, 32'hA5A5A5A5, 0, 2);
    check("rdata_hold", rdata_o, 32'h00008001);
    txn(0, 3'b001, 32'h10, 0, 32'h1234F00D, 0, 1, 0, 0,
        32'h10, 4'b0011, 0, 32'hFFFFF00D, 3);
    txn(0, 3'b100, 32'h11, 0, 32'h1234F0AB, 0, 1, 0, 0,
        32'h10, 4'b0010, 0, 32'h000000F0, 3);
    txn(0, 3'b010, 32'h20, 0, 32'hCAFEBABE, 2, 2, 1, 0,
        32'h20, 4'b1111, 0, 32'hCAFEBABE, 6);
    txn(0, 3'b011, 32'h30, 0, 32'h89ABCDEF, 0, 1, 0, 0,
        32'h30, 4'b1111, 0, 32'h89ABCDEF, 3);
    txn(1, 3'b110, 32'h44, 32'h11223344, 0, 0, 0, 0, 0,
        32'h44, 4'b1111, 32'h11223344, 0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    txn(0, 3'b010, 32'h102, 0, 32'h55667788, 0, 1, 0, 1,
        0, 0, 0, 0, 1);
    txn(1, 3'b001, 32'h5, 32'h0000BEEF, 0, 0, 0, 0, 1,
        0, 0, 0, 0, 1);
    txn(0, 3'b001, 32'h7, 0, 32'h80001234, 0, 1, 0, 1,
        0, 0, 0, 0, 1);
`else
    txn(0, 3'b010, 32'h102, 0, 32'h55667788, 0, 1, 0, 0,
        32'h100, 4'b1111, 0, 32'h55667788, 3);
    txn(1, 3'b001, 32'h5, 32'h0000BEEF, 0, 0, 0, 0, 0,
        32'h4, 4'b0011, 32'hBEEFBEEF, 0, 2);
    txn(0, 3'b001, 32'h7, 0, 32'h80001234, 0, 1, 0, 0,
        32'h4, 4'b1100, 0, 32'hFFFF8000, 3);
`endif
    check("rdata_hold2", rdata_o, last_rd);
    check("misalign_idle", {31'h0, misalign_o}, 32'h0);

    // Reset asserted while the load waits for read data.
    e.we = 1'b0; e.addr = 32'h40; e.be = 4'b1111; e.wdata = 32'h0;
    bus_q.push_back(e);
    req_valid_i = 1'b1; req_write_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h40;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus_gnt_i = 1'b0;
    check("wait_stall", {31'h0, stall_o}, 32'h1);
    reset_ni = 1'b0;
    #1;
    check("abort_bus_req", {31'h0, bus_req_o}, 32'h0);
    check("abort_stall", {31'h0, stall_o}, 32'h0);
    check("abort_rdata", rdata_o, 32'h0);
    check("abort_addr", bus_addr_o, 32'h0);
    req_valid_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    bus_rvalid_i = 1'b0;
    check("post_rst_rdata", rdata_o, 32'h0);
    check("post_rst_req", {31'h0, bus_req_o}, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;

    check("bus_q_left", bus_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("stall_q_left", stall_q.size(), 0);
    check("mis_q_left", mis_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
